imem_arbiter: RTL

Single-port access controller for the ideal instruction memory, shared between the CPU fetch stage and a program loader/debug port. It grants at most one transaction per cycle to one requester using round-robin arbitration. It drives the memory's word address, write enable and write data. It registers the read word into a one-cycle response to the granted requester. A loader-controlled hold mode blocks fetch entirely so a program image can be loaded before the core runs.

---
 rtl/imem_pkg.sv | 16 +
 rtl/imem_arbiter_if.sv | 41 ++++
 rtl/imem_rr_pick.sv | 29 ++
 rtl/imem_arbiter.sv | 106 ++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory arbiter slice.
package imem_pkg;

  typedef enum logic {
    RUN,
    LOAD
  } state_t;

  localparam logic REQ_FETCH = 1'b0;
  localparam logic REQ_LOAD  = 1'b1;

  localparam int unsigned ADDR_W_DEF = 30;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 32;

endpackage

// File: rtl/imem_arbiter_if.sv
// Fetch, loader and memory-side signals of the instruction-memory arbiter.
interface imem_arbiter_if
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata;

  logic              l_req;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic              l_hold;
  logic              l_gnt;
  logic              l_rvalid;
  logic [DATA_W-1:0] l_rdata;

  logic [ADDR_W-1:0] m_addr;
  logic              m_w_en;
  logic [DATA_W-1:0] m_data_in;
  logic [DATA_W-1:0] m_dword;

  modport slave (
    input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_hold, m_dword,
    output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
           m_addr, m_w_en, m_data_in
  );

  modport master (
    output f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_hold, m_dword,
    input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata,
           m_addr, m_w_en, m_data_in
  );

endinterface

// File: rtl/imem_rr_pick.sv
// Two-input round-robin picker; purely combinational, history kept by the caller.
module imem_rr_pick
  import imem_pkg::*;
(
  input  logic f_req,
  input  logic l_req,
  input  logic last,
  input  logic f_mask,
  output logic f_gnt,
  output logic l_gnt
);

  logic f_ok;

  always_comb begin
    f_ok  = f_req & ~f_mask;
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (f_ok && l_req) begin
      // Contest: the side not served most recently wins.
      f_gnt = (last == REQ_LOAD);
      l_gnt = (last == REQ_FETCH);
    end else begin
      f_gnt = f_ok;
      l_gnt = l_req & ~f_ok;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// Single-port instruction-memory access controller: fetch vs loader, with a hold mode.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  imem_arbiter_if.slave    bus,
  output logic             held,
  output logic [CNT_W-1:0] f_cnt,
  output logic [CNT_W-1:0] l_cnt
);

  state_t            state, state_nxt;
  logic              last;
  logic              f_mask;
  logic              f_gnt, l_gnt;
  logic [ADDR_W-1:0] addr_sel;
  logic              f_rvalid_q, l_rvalid_q;
  logic [DATA_W-1:0] f_rdata_q, l_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    held      = 1'b0;
    f_mask    = 1'b0;
    case (state)
      RUN: begin
        if (bus.l_hold) state_nxt = LOAD;
      end
      LOAD: begin
        held   = 1'b1;
        f_mask = 1'b1;
        if (!bus.l_hold) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  imem_rr_pick u_pick (
    .f_req  (bus.f_req),
    .l_req  (bus.l_req),
    .last   (last),
    .f_mask (f_mask),
    .f_gnt  (f_gnt),
    .l_gnt  (l_gnt)
  );

  always_comb begin
    addr_sel = l_gnt ? bus.l_addr : bus.f_addr;
  end

  assign bus.f_gnt     = f_gnt;
  assign bus.l_gnt     = l_gnt;
  assign bus.m_addr    = addr_sel;
  assign bus.m_w_en    = l_gnt & bus.l_we;
  assign bus.m_data_in = bus.l_wdata;

  // Leaving LOAD marks the loader as last served so fetch wins the first contest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= REQ_LOAD;
    end else if (state == LOAD && state_nxt == RUN) begin
      last <= REQ_LOAD;
    end else if (f_gnt) begin
      last <= REQ_FETCH;
    end else if (l_gnt) begin
      last <= REQ_LOAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_rvalid_q <= 1'b0;
      l_rvalid_q <= 1'b0;
      f_rdata_q  <= '0;
      l_rdata_q  <= '0;
      f_cnt      <= '0;
      l_cnt      <= '0;
    end else begin
      f_rvalid_q <= f_gnt;
      l_rvalid_q <= l_gnt;
      if (f_gnt) begin
        f_rdata_q <= bus.m_dword;
        f_cnt     <= f_cnt + CNT_W'(1);
      end
      if (l_gnt) begin
        l_rdata_q <= bus.l_we ? bus.l_wdata : bus.m_dword;
        l_cnt     <= l_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.f_rvalid = f_rvalid_q;
  assign bus.f_rdata  = f_rdata_q;
  assign bus.l_rvalid = l_rvalid_q;
  assign bus.l_rdata  = l_rdata_q;

endmodule
